// File: rtl/risc_run_ctrl.sv
`timescale 1ns / 1ps
// risc_run_ctrl: run/load sequencer for the tt_um_risc CPU core.
// Owns the instruction-memory write port and the CPU reset/enable. Host commands
// (LOAD, RUN, STEP, STOP) arrive over a valid/ready handshake. Enabled cycles are
// counted with saturation.
// Optional feature: define RISC_BREAKPOINT_EN to halt RUN when cpu_pc matches bp_addr.
module risc_run_ctrl #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CYC_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid_i,
   input  logic [1:0]        cmd_op_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_data_i,
   output logic              cmd_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [DATA_W-1:0] imem_wdata_o,
   output logic              cpu_rst_n_o,
   output logic              cpu_en_o,
   input  logic [ADDR_W-1:0] cpu_pc_i,
   input  logic              cpu_halt_i,
   input  logic              bp_valid_i,
   input  logic [ADDR_W-1:0] bp_addr_i,
   output logic [1:0]        state_o,
   output logic [CYC_W-1:0]  cycle_cnt_o,
   output logic              bp_hit_o
);

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StLoad   = 2'b01,
      StRun    = 2'b10,
      StHalted = 2'b11
   } state_e;

   localparam logic [1:0] OpLoad = 2'b00;
   localparam logic [1:0] OpRun  = 2'b01;
   localparam logic [1:0] OpStep = 2'b10;
   localparam logic [1:0] OpStop = 2'b11;

   localparam logic [CYC_W-1:0] CycMax = '1;

   state_e            state_q;
   logic              cmd_ready_q;
   logic              imem_we_q;
   logic [ADDR_W-1:0] imem_addr_q;
   logic [DATA_W-1:0] imem_wdata_q;
   logic              cpu_rst_n_q;
   logic              cpu_en_q;
   logic [CYC_W-1:0]  cycle_cnt_q;
   logic              bp_hit_q;

   logic              cmd_acc;
   logic              bp_match;

`ifdef RISC_BREAKPOINT_EN
   // Breakpoint compare against the PC the CPU presents in this cycle.
   always_comb begin
      bp_match = bp_valid_i & (cpu_pc_i == bp_addr_i);
   end
`else
   logic unused_bp;
   assign unused_bp = ^{bp_valid_i, bp_addr_i, cpu_pc_i};

   // Breakpoint logic not built: never matches.
   always_comb begin
      bp_match = 1'b0;
   end
`endif

   // Handshake: ready is registered and is low only while in LOAD.
   always_comb begin
      cmd_acc = cmd_valid_i & cmd_ready_q;
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cmd_ready_q  <= 1'b1;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_rst_n_q  <= 1'b0;
         cpu_en_q     <= 1'b0;
         cycle_cnt_q  <= '0;
         bp_hit_q     <= 1'b0;
      end else begin
         // Defaults: single-cycle strobes drop, CPU out of reset, ready high.
         imem_we_q   <= 1'b0;
         cpu_en_q    <= 1'b0;
         cpu_rst_n_q <= 1'b1;
         cmd_ready_q <= 1'b1;

         // Count edges on which the CPU advanced; saturate instead of wrapping.
         if (cpu_en_q && (cycle_cnt_q != CycMax)) begin
            cycle_cnt_q <= cycle_cnt_q + 1'b1;
         end

         unique case (state_q)
            StIdle, StHalted: begin
               if (cmd_acc) begin
                  case (cmd_op_i)
                     OpLoad: begin
                        state_q      <= StLoad;
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= cmd_addr_i;
                        imem_wdata_q <= cmd_data_i;
                        cpu_rst_n_q  <= 1'b0;
                        cmd_ready_q  <= 1'b0;
                        cycle_cnt_q  <= '0;
                        bp_hit_q     <= 1'b0;
                     end
                     OpRun: begin
                        state_q  <= StRun;
                        cpu_en_q <= 1'b1;
                        bp_hit_q <= 1'b0;
                     end
                     OpStep: begin
                        // One enabled cycle; the state stays where it is.
                        cpu_en_q <= 1'b1;
                     end
                     OpStop: begin
                        // Nothing running, nothing to stop.
                     end
                     default: begin
                     end
                  endcase
               end
            end
            StLoad: begin
               // The write strobe lasted one cycle; release the CPU.
               state_q <= StIdle;
            end
            StRun: begin
               // Priority: CPU halt, then breakpoint, then host STOP.
               if (cpu_halt_i) begin
                  state_q <= StHalted;
               end else if (bp_match) begin
                  state_q  <= StHalted;
                  bp_hit_q <= 1'b1;
               end else if (cmd_acc && (cmd_op_i == OpStop)) begin
                  state_q <= StIdle;
               end else begin
                  cpu_en_q <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign state_o      = state_q;
   assign cmd_ready_o  = cmd_ready_q;
   assign imem_we_o    = imem_we_q;
   assign imem_addr_o  = imem_addr_q;
   assign imem_wdata_o = imem_wdata_q;
   assign cpu_rst_n_o  = cpu_rst_n_q;
   assign cpu_en_o     = cpu_en_q;
   assign cycle_cnt_o  = cycle_cnt_q;
   assign bp_hit_o     = bp_hit_q;

endmodule
